// File: rtl/gate_pattern_checker.sv
// Sweeps the four (A,B) input patterns into a gate under test, samples Y on the
// last hold cycle of each pattern and reports per-pattern mismatches.
module gate_pattern_checker #(
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned GATE_OP     = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       Y,
    output logic       A,
    output logic       B,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned ERR_W = 3;
    localparam int unsigned VEC_W = 4;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(3);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   hold_cnt;

    logic               expected_c;
    logic               mismatch_c;
    logic [IDX_W-1:0]   idx_next_c;
    logic [ERR_W-1:0]   err_next_c;
    logic [VEC_W-1:0]   fail_next_c;

    // Reference gate function, evaluated on the registered stimulus
    always_comb begin
        expected_c = 1'b0;
        case (GATE_OP)
            0:       expected_c = A & B;
            1:       expected_c = A | B;
            2:       expected_c = A ^ B;
            default: expected_c = ~(A & B);
        endcase
    end

    // Scoreboard update applied on the sampling edge of each pattern
    always_comb begin
        mismatch_c       = Y ^ expected_c;
        idx_next_c       = idx + IDX_W'(1);
        err_next_c       = err_count + ERR_W'(mismatch_c);
        fail_next_c      = fail_vec;
        fail_next_c[idx] = fail_vec[idx] | mismatch_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            hold_cnt  <= '0;
            A         <= 1'b0;
            B         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // A new sweep may start straight from DONE
                    if (start) begin
                        state     <= DRIVE;
                        idx       <= '0;
                        hold_cnt  <= '0;
                        A         <= 1'b0;
                        B         <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_count <= '0;
                        fail_vec  <= '0;
                    end
                end
                DRIVE: begin
                    if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end else begin
                        err_count <= err_next_c;
                        fail_vec  <= fail_next_c;
                        hold_cnt  <= '0;
                        if (idx != IDX_LAST) begin
                            // Pattern order 00,10,01,11: A is idx bit 0, B is idx bit 1
                            idx <= idx_next_c;
                            A   <= idx_next_c[0];
                            B   <= idx_next_c[1];
                        end else begin
                            state <= DONE;
                            idx   <= '0;
                            A     <= 1'b0;
                            B     <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next_c == '0);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_pattern_checker.sv
// Randomized self-checking bench for gate_pattern_checker: three instances with
// different gate functions and hold lengths, checked against a sweep-level model.
module tb_gate_pattern_checker;

    localparam int NDUT = 3;
    localparam int OP_T   [NDUT] = '{0, 3, 2};
    localparam int HOLD_T [NDUT] = '{2, 3, 1};

    logic       clk;
    logic       rst_n;
    logic       start_v   [NDUT];
    logic       y_w       [NDUT];
    logic       a_w       [NDUT];
    logic       b_w       [NDUT];
    logic       busy_w    [NDUT];
    logic       done_w    [NDUT];
    logic       pass_w    [NDUT];
    logic [2:0] err_w     [NDUT];
    logic [3:0] fail_w    [NDUT];

    logic inj;
    logic stuck;
    int   tests;
    int   fails;

    function automatic logic ref_gate(input int op, input logic a, input logic b);
        case (op)
            0:       return a & b;
            1:       return a | b;
            2:       return a ^ b;
            default: return !(a & b);
        endcase
    endfunction

    // Gate under test: ideal gate, optionally corrupted or stuck high
    assign y_w[0] = stuck ? 1'b1 : (ref_gate(OP_T[0], a_w[0], b_w[0]) ^ inj);
    assign y_w[1] = stuck ? 1'b1 : (ref_gate(OP_T[1], a_w[1], b_w[1]) ^ inj);
    assign y_w[2] = stuck ? 1'b1 : (ref_gate(OP_T[2], a_w[2], b_w[2]) ^ inj);

    gate_pattern_checker #(.HOLD_CYCLES(2), .GATE_OP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .Y(y_w[0]),
        .A(a_w[0]), .B(b_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .pass(pass_w[0]), .err_count(err_w[0]), .fail_vec(fail_w[0])
    );
    gate_pattern_checker #(.HOLD_CYCLES(3), .GATE_OP(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .Y(y_w[1]),
        .A(a_w[1]), .B(b_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .pass(pass_w[1]), .err_count(err_w[1]), .fail_vec(fail_w[1])
    );
    gate_pattern_checker #(.HOLD_CYCLES(1), .GATE_OP(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .Y(y_w[2]),
        .A(a_w[2]), .B(b_w[2]), .busy(busy_w[2]), .done(done_w[2]),
        .pass(pass_w[2]), .err_count(err_w[2]), .fail_vec(fail_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One sweep on instance s. exp_mask lists the patterns whose sample must
    // mismatch; noise 0=clean, 1=always wrong, 2=random on non-sampling cycles.
    task automatic do_sweep(input int s, input logic [3:0] exp_mask, input int noise,
                            input bit poke, input string name);
        int h;
        h = HOLD_T[s];
        @(negedge clk);
        start_v[s] = 1'b1;
        for (int k = 0; k < 4 * h; k++) begin
            int p;
            p = k / h;
            @(negedge clk);
            start_v[s] = (poke && k == h) ? 1'b1 : 1'b0;
            tests++;
            if (busy_w[s] !== 1'b1 || done_w[s] !== 1'b0 ||
                a_w[s] !== p[0] || b_w[s] !== p[1]) begin
                fails++;
                $display("FAIL %s cycle %0d: busy=%b done=%b AB=%b%b, required busy=1 done=0 AB=%b%b",
                         name, k, busy_w[s], done_w[s], a_w[s], b_w[s], p[0], p[1]);
            end
            if (k % h == h - 1)
                inj = exp_mask[p];
            else if (noise == 1)
                inj = 1'b1;
            else if (noise == 2)
                inj = 1'($urandom);
            else
                inj = 1'b0;
        end
        @(negedge clk);
        start_v[s] = 1'b0;
        inj = 1'b0;
        for (int r = 0; r < 2; r++) begin
            tests++;
            if (busy_w[s] !== 1'b0 || done_w[s] !== 1'b1 || a_w[s] !== 1'b0 || b_w[s] !== 1'b0 ||
                pass_w[s] !== (exp_mask == 4'b0000) || err_w[s] !== 3'($countones(exp_mask)) ||
                fail_w[s] !== exp_mask) begin
                fails++;
                $display("FAIL %s result[%0d]: busy=%b done=%b AB=%b%b pass=%b err=%0d vec=%b, required 0 1 00 %b %0d %b",
                         name, r, busy_w[s], done_w[s], a_w[s], b_w[s], pass_w[s], err_w[s], fail_w[s],
                         exp_mask == 4'b0000, $countones(exp_mask), exp_mask);
            end
            if (r == 0) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int s = 0; s < NDUT; s++) begin
            tests++;
            if ({a_w[s], b_w[s], busy_w[s], done_w[s], pass_w[s], err_w[s], fail_w[s]} !== 12'd0) begin
                fails++;
                $display("FAIL reset_hold dut%0d: outputs=%b, required all 0", s,
                         {a_w[s], b_w[s], busy_w[s], done_w[s], pass_w[s], err_w[s], fail_w[s]});
            end
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy_w[0], done_w[0]);
        end
        // Leave a nonzero result, then reset asynchronously mid-cycle
        do_sweep(0, 4'b1010, 0, 1'b0, "pre_reset");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({a_w[0], b_w[0], busy_w[0], done_w[0], pass_w[0], err_w[0], fail_w[0]} !== 12'd0) begin
            fails++;
            $display("FAIL async_reset: outputs=%b, required all 0",
                     {a_w[0], b_w[0], busy_w[0], done_w[0], pass_w[0], err_w[0], fail_w[0]});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_and_clean();
        do_sweep(0, 4'b0000, 0, 1'b0, "and_clean");
    endtask

    task automatic test_stuck_high();
        stuck = 1'b1;
        do_sweep(0, 4'b0111, 0, 1'b0, "and_stuck1");
        do_sweep(1, 4'b1000, 0, 1'b0, "nand_stuck1");
        do_sweep(2, 4'b1001, 0, 1'b0, "xor_stuck1");
        stuck = 1'b0;
    endtask

    task automatic test_hold3_noise();
        do_sweep(1, 4'b0000, 1, 1'b0, "hold3_early_wrong");
    endtask

    task automatic test_random();
        for (int n = 0; n < 9; n++) begin
            logic [3:0] m;
            m = 4'($urandom);
            do_sweep(n % NDUT, m, 2, 1'b0, "random_sweep");
        end
    endtask

    task automatic test_start_ignored();
        do_sweep(0, 4'b0110, 2, 1'b1, "start_in_drive");
        do_sweep(1, 4'b0001, 2, 1'b1, "start_in_drive_h3");
    endtask

    task automatic test_back_to_back();
        logic [3:0] masks [3];
        masks[0] = 4'b0101;
        masks[1] = 4'b0000;
        masks[2] = 4'b1000;
        @(negedge clk);
        start_v[0] = 1'b1;
        for (int k = 0; k < 27; k++) begin
            int ph;
            int sw;
            int p;
            ph = k % 9;
            sw = k / 9;
            p  = ph / 2;
            @(negedge clk);
            start_v[0] = (k < 19) ? 1'b1 : 1'b0;
            tests++;
            if (busy_w[0] !== (ph < 8) || done_w[0] !== (ph == 8)) begin
                fails++;
                $display("FAIL b2b_phase cycle %0d: busy=%b done=%b, required %b %b",
                         k, busy_w[0], done_w[0], ph < 8, ph == 8);
            end
            if (ph < 8) begin
                tests++;
                if (a_w[0] !== p[0] || b_w[0] !== p[1]) begin
                    fails++;
                    $display("FAIL b2b_ab cycle %0d: AB=%b%b, required %b%b",
                             k, a_w[0], b_w[0], p[0], p[1]);
                end
            end
            if (ph == 8) begin
                tests++;
                if (err_w[0] !== 3'($countones(masks[sw])) || fail_w[0] !== masks[sw] ||
                    pass_w[0] !== (masks[sw] == 4'b0000)) begin
                    fails++;
                    $display("FAIL b2b_result sweep %0d: err=%0d vec=%b pass=%b, required %0d %b %b",
                             sw, err_w[0], fail_w[0], pass_w[0], $countones(masks[sw]), masks[sw],
                             masks[sw] == 4'b0000);
                end
            end
            if (ph == 0 && sw > 0) begin
                tests++;
                if (err_w[0] !== 3'd0 || fail_w[0] !== 4'd0 || pass_w[0] !== 1'b0) begin
                    fails++;
                    $display("FAIL b2b_clear sweep %0d: err=%0d vec=%b pass=%b, required 0 0000 0",
                             sw, err_w[0], fail_w[0], pass_w[0]);
                end
            end
            inj = (ph < 8 && ph % 2 == 1) ? masks[sw][p] : 1'b0;
        end
        inj = 1'b0;
    endtask

    task automatic test_reset_mid_sweep();
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        inj = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int s = 0; s < NDUT; s++) begin
            tests++;
            if ({a_w[s], b_w[s], busy_w[s], done_w[s], pass_w[s], err_w[s], fail_w[s]} !== 12'd0) begin
                fails++;
                $display("FAIL mid_sweep_reset dut%0d: outputs=%b, required all 0", s,
                         {a_w[s], b_w[s], busy_w[s], done_w[s], pass_w[s], err_w[s], fail_w[s]});
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        inj = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (busy_w[0] !== 1'b0 || done_w[0] !== 1'b0 || err_w[0] !== 3'd0) begin
            fail_msg: begin
                fails++;
                $display("FAIL stay_idle: busy=%b done=%b err=%0d, required 0 0 0",
                         busy_w[0], done_w[0], err_w[0]);
            end
        end
        do_sweep(0, 4'b0000, 0, 1'b0, "after_mid_reset");
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        inj   = 1'b0;
        stuck = 1'b0;
        for (int s = 0; s < NDUT; s++) start_v[s] = 1'b0;
        test_reset();
        test_and_clean();
        test_stuck_high();
        test_hold3_noise();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
